// File: rtl/switch_event_ctrl.sv
// Switch-bank event controller: samples debounced switches, latches edge events into PENDING and drives a masked level interrupt.
// Optional macro SWITCH_EVT_SYNC_EN adds a 2-flop input synchronizer and extends priming to match.
module switch_event_ctrl #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_MASK = '0,
  parameter logic [WIDTH-1:0] RESET_EDGE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Read,
  input  logic             Write,
  input  logic [1:0]       Address,
  input  logic [WIDTH-1:0] DataIn,
  output logic [WIDTH-1:0] DataOut,
  output logic             Ack,
  input  logic [WIDTH-1:0] Switch_in,
  output logic             Interrupt
);

  typedef enum logic {IDLE, ACK} bus_state_t;

  bus_state_t state, state_next;

  logic [WIDTH-1:0] cur_q, prev_q;
  logic [WIDTH-1:0] pending, mask, edge_mode;
  logic [WIDTH-1:0] rise, fall, evt, clr;
  logic [WIDTH-1:0] data_next;
  logic             primed;
  logic             ack_next;
  logic             wr_pending, wr_mask, wr_edge;

`ifdef SWITCH_EVT_SYNC_EN
  logic [WIDTH-1:0] sync1, sync2;
  logic [2:0]       prime_sr;

  // Detection stays off until the synchronizer and sample pair hold post-reset data.
  always_ff @(posedge clock) begin
    sync1  <= Switch_in;
    sync2  <= sync1;
    cur_q  <= sync2;
    prev_q <= cur_q;
    if (reset) prime_sr <= '0;
    else       prime_sr <= {prime_sr[1:0], 1'b1};
  end

  assign primed = prime_sr[2];
`else
  logic prime_q;

  always_ff @(posedge clock) begin
    cur_q  <= Switch_in;
    prev_q <= cur_q;
    if (reset) prime_q <= 1'b0;
    else       prime_q <= 1'b1;
  end

  assign primed = prime_q;
`endif

  assign rise = cur_q & ~prev_q;
  assign fall = ~cur_q & prev_q;
  assign evt  = {WIDTH{primed}} & (rise | (edge_mode & fall));
  assign clr  = wr_pending ? DataIn : '0;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Register side effects fire only on the IDLE->ACK step; a write wins over a simultaneous read.
  always_comb begin
    state_next = state;
    ack_next   = Ack;
    data_next  = DataOut;
    wr_pending = 1'b0;
    wr_mask    = 1'b0;
    wr_edge    = 1'b0;
    case (state)
      IDLE: begin
        ack_next = 1'b0;
        if (Read || Write) begin
          state_next = ACK;
          ack_next   = 1'b1;
          if (Write) begin
            case (Address)
              2'd1:    wr_pending = 1'b1;
              2'd2:    wr_mask    = 1'b1;
              2'd3:    wr_edge    = 1'b1;
              default: ;
            endcase
          end else begin
            case (Address)
              2'd0:    data_next = cur_q;
              2'd1:    data_next = pending;
              2'd2:    data_next = mask;
              default: data_next = edge_mode;
            endcase
          end
        end
      end
      ACK: begin
        if (!Read && !Write) begin
          state_next = IDLE;
          ack_next   = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        ack_next   = 1'b0;
      end
    endcase
  end

  // New events override a same-cycle clear, and latch whatever the mask says.
  always_ff @(posedge clock) begin
    if (reset) begin
      Ack       <= 1'b0;
      DataOut   <= '0;
      Interrupt <= 1'b0;
      pending   <= '0;
      mask      <= RESET_MASK;
      edge_mode <= RESET_EDGE;
    end else begin
      Ack       <= ack_next;
      DataOut   <= data_next;
      Interrupt <= |(pending & mask);
      pending   <= evt | (pending & ~clr);
      if (wr_mask) mask      <= DataIn;
      if (wr_edge) edge_mode <= DataIn;
    end
  end

endmodule

// File: tb/tb_switch_event_ctrl.sv
// Self-checking bench for switch_event_ctrl: bus reads are scoreboarded through a queue of expected read data.
module tb_switch_event_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       Read, Write;
  logic [1:0] Address;
  logic [7:0] DataIn, DataOut, Switch_in;
  logic       Ack, Interrupt;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];

  switch_event_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .Read     (Read),
    .Write    (Write),
    .Address  (Address),
    .DataIn   (DataIn),
    .DataOut  (DataOut),
    .Ack      (Ack),
    .Switch_in(Switch_in),
    .Interrupt(Interrupt)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Starts a handshake and insists Ack rises exactly one cycle later.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] addr, input logic [7:0] data);
    @(negedge clock);
    Read    = rd;
    Write   = wr;
    Address = addr;
    DataIn  = data;
    @(negedge clock);
    checkOutput("ack_rise", {7'b0, Ack}, 8'h01);
    if (!Ack) begin
      for (int i = 0; i < 8 && !Ack; i++) @(negedge clock);
      checkOutput("ack_timeout", {7'b0, Ack}, 8'h01);
    end
  endtask

  task automatic checkReadData(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    checkOutput(tag, DataOut, e);
  endtask

  task automatic busRelease();
    Read  = 1'b0;
    Write = 1'b0;
    @(negedge clock);
    checkOutput("ack_fall", {7'b0, Ack}, 8'h00);
  endtask

  task automatic busRead(input logic [1:0] addr, input logic [7:0] expected, input string tag);
    exp_q.push_back(expected);
    applyStimulus(1'b1, 1'b0, addr, 8'h00);
    checkReadData(tag);
    busRelease();
  endtask

  task automatic busWrite(input logic [1:0] addr, input logic [7:0] data);
    applyStimulus(1'b0, 1'b1, addr, data);
    busRelease();
  endtask

  task automatic checkIrq(input string tag, input logic expected);
    checkOutput(tag, {7'b0, Interrupt}, {7'b0, expected});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Read      = 1'b0;
    Write     = 1'b0;
    Address   = 2'd0;
    DataIn    = 8'h00;
    Switch_in = 8'h00;
    reset     = 1'b1;
    waitCycles(3);
    // Switches appear on the last reset edge; priming must hide them.
    Switch_in = 8'h0F;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_ack", {7'b0, Ack}, 8'h00);
    checkOutput("rst_dataout", DataOut, 8'h00);
    checkIrq("rst_irq", 1'b0);

    busWrite(2'd2, 8'hFF);
    waitCycles(3);
    checkIrq("prime_irq", 1'b0);
    busRead(2'd1, 8'h00, "prime_pending");
    busRead(2'd2, 8'hFF, "mask_ff");
    busRead(2'd3, 8'h00, "edge_reset");
    busRead(2'd0, 8'h0F, "switch_0f");

    busWrite(2'd2, 8'h01);
    @(negedge clock);
    Switch_in = 8'h0E;
    waitCycles(4);
    checkIrq("fall_noevt_irq", 1'b0);
    busRead(2'd1, 8'h00, "fall_noevt_pending");

    @(negedge clock);
    Switch_in = 8'h0F;
    @(negedge clock);
    checkIrq("rise_irq_e0", 1'b0);
    @(negedge clock);
    checkIrq("rise_irq_e1", 1'b0);
    @(negedge clock);
    checkIrq("rise_irq_e2", 1'b1);
    busRead(2'd1, 8'h01, "rise_pending");
    busWrite(2'd1, 8'h01);
    checkIrq("clr_irq", 1'b0);
    @(negedge clock);
    Switch_in = 8'h0E;
    waitCycles(4);
    busRead(2'd1, 8'h00, "fall_after_clr");
    checkIrq("fall_after_clr_irq", 1'b0);

    @(negedge clock);
    Switch_in = 8'h8E;
    waitCycles(4);
    busRead(2'd1, 8'h80, "bit7_rise");
    busWrite(2'd1, 8'h80);
    busWrite(2'd3, 8'h80);
    busRead(2'd3, 8'h80, "edge_80");
    @(negedge clock);
    Switch_in = 8'h0E;
    waitCycles(4);
    busRead(2'd1, 8'h80, "bit7_fall");
    checkIrq("bit7_masked_irq", 1'b0);
    busWrite(2'd2, 8'h80);
    checkIrq("bit7_unmasked_irq", 1'b1);

    busWrite(2'd1, 8'h80);
    checkIrq("bit7_clr_irq", 1'b0);
    busWrite(2'd2, 8'h01);
    // Clear write lands on the same edge the bit0 event is latched.
    @(negedge clock);
    Switch_in = 8'h0F;
    busWrite(2'd1, 8'h01);
    checkIrq("setwins_irq", 1'b1);
    busRead(2'd1, 8'h01, "setwins_pending");
    busWrite(2'd1, 8'h01);
    checkIrq("late_clr_irq", 1'b0);
    busRead(2'd1, 8'h00, "late_clr_pending");

    @(negedge clock);
    Switch_in = 8'hA5;
    waitCycles(3);
    exp_q.push_back(8'hA5);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h00);
    checkReadData("rd_switch_a5");
    Switch_in = 8'h5A;
    waitCycles(10);
    checkOutput("hold_read_ack", {7'b0, Ack}, 8'h01);
    exp_q.push_back(8'hA5);
    checkReadData("hold_read_data");
    busRelease();
    waitCycles(3);
    busRead(2'd1, 8'hFA, "pending_fa");
    checkIrq("pending_fa_irq", 1'b0);

    applyStimulus(1'b0, 1'b1, 2'd1, 8'hFF);
    Switch_in = 8'h5B;
    waitCycles(10);
    checkOutput("hold_write_ack", {7'b0, Ack}, 8'h01);
    busRelease();
    busRead(2'd1, 8'h01, "single_clear");
    checkIrq("single_clear_irq", 1'b1);

    exp_q.push_back(8'h01);
    applyStimulus(1'b1, 1'b0, 2'd2, 8'h00);
    checkReadData("pre_reset_mask");
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midrst_ack", {7'b0, Ack}, 8'h00);
    checkOutput("midrst_dataout", DataOut, 8'h00);
    checkIrq("midrst_irq", 1'b0);
    reset = 1'b0;
    Read  = 1'b0;
    waitCycles(2);
    busRead(2'd2, 8'h00, "midrst_mask");
    busRead(2'd1, 8'h00, "midrst_pending");
    busRead(2'd3, 8'h00, "midrst_edge");

    busRead(2'd0, 8'h5B, "switch_5b");
    exp_q.push_back(8'h5B);
    applyStimulus(1'b1, 1'b1, 2'd2, 8'h3C);
    checkReadData("rw_dataout_kept");
    busRelease();
    busRead(2'd2, 8'h3C, "rw_mask_written");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
